serial_addsub_seq: RTL and testbench

- Bit-serial add/subtract engine that time-multiplexes one full-adder cell (sum = x^y^cin, carry = majority) over WIDTH cycles.
- Replaces a WIDTH-bit ripple array in lab datapaths where area matters more than latency.
- Sequences operand shift registers, the carry flip-flop and the bit counter, and presents a start/busy/done handshake to the surrounding lab controller.

---
 rtl/serial_addsub_seq_if.sv | 36 +++
 rtl/serial_addsub_seq.sv | 103 ++++++++++
 tb/tb_serial_addsub_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_seq_if
// Handshake and operand/result bundle for the bit-serial add/subtract engine.
//   start : request, sampled only while the engine is idle
//   sub   : 0 = a+b, 1 = a-b, captured together with the operands
//   a, b  : WIDTH-bit operands, captured on the accepting edge
//   busy  : high while the engine is stepping through the bits
//   done  : one-cycle completion pulse
//   sum   : WIDTH-bit result, registered and held until the next result
//   cout  : final carry out (for subtract: 1 = no borrow)
//   ovf   : two's-complement overflow
// Modports: master = lab controller side, slave = engine side.
// ---------------------------------------------------------------------------
interface serial_addsub_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_seq.sv
// ---------------------------------------------------------------------------
// serial_addsub_seq
// Bit-serial add/subtract engine. One full-adder cell is reused over WIDTH
// clock cycles, LSB first, instead of a WIDTH-bit ripple array.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_seq_if.slave (start/sub/a/b in,
//           busy/done/sum/cout/ovf out)
// Parameter:
//   WIDTH : operand/result width, 2..32
// ---------------------------------------------------------------------------
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_addsub_seq_if.slave    bus
);

    localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_resSh;
    logic             r_carry;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sumBit;
    logic             w_carry;
    logic [WIDTH-1:0] w_resNext;
    logic             w_lastBit;

    // The shared full-adder cell working on the current LSBs.
    assign w_sumBit  = r_aSh[0] ^ r_bSh[0] ^ r_carry;
    assign w_carry   = (r_aSh[0] & r_bSh[0]) | (r_aSh[0] & r_carry) | (r_bSh[0] & r_carry);
    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_resNext = {w_sumBit, r_resSh[WIDTH-1:1]};
    assign w_lastBit = (r_cnt == CNTW'(WIDTH - 1));

    // Subtraction is a + ~b + 1: operand B is inverted on capture and the
    // carry flip-flop is preloaded with 1. On the final bit the carry flop
    // still holds the carry into the MSB, which gives overflow directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_resSh <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_aSh   <= bus.a;
                        r_bSh   <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_resSh <= w_resNext;
                    r_aSh   <= r_aSh >> 1;
                    r_bSh   <= r_bSh >> 1;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_lastBit) begin
                        r_sum   <= w_resNext;
                        r_cout  <= w_carry;
                        r_ovf   <= r_carry ^ w_carry;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_seq
// Directed and randomised checks of the bit-serial add/subtract engine at
// WIDTH=8, plus one directed vector on a WIDTH=4 instance.
// ---------------------------------------------------------------------------
module tb_serial_addsub_seq;

    logic clk;
    logic rst_n;

    int totalCount;
    int badCount;

    serial_addsub_seq_if #(.WIDTH(8)) bus8 ();
    serial_addsub_seq_if #(.WIDTH(4)) bus4 ();

    serial_addsub_seq #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_addsub_seq #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected)
        else begin
            badCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] aVal,
                                 input logic [7:0] bVal, input logic subVal);
        bus8.start = st;
        bus8.a     = aVal;
        bus8.b     = bVal;
        bus8.sub   = subVal;
    endtask

    // Independent arithmetic reference: returns {ovf, cout, sum}.
    function automatic logic [9:0] refModel(input logic [7:0] aVal,
                                            input logic [7:0] bVal, input logic subVal);
        logic [8:0] wide;
        logic [7:0] res;
        logic       c;
        logic       o;
        if (subVal) begin
            wide = {1'b0, aVal} - {1'b0, bVal};
            res  = wide[7:0];
            c    = (aVal >= bVal);
            o    = (aVal[7] != bVal[7]) && (res[7] != aVal[7]);
        end else begin
            wide = {1'b0, aVal} + {1'b0, bVal};
            res  = wide[7:0];
            c    = wide[8];
            o    = (aVal[7] == bVal[7]) && (res[7] != aVal[7]);
        end
        return {o, c, res};
    endfunction

    // One full operation from IDLE: latency, busy length, result, done width.
    task automatic runOp(input string tag, input logic [7:0] aVal, input logic [7:0] bVal,
                         input logic subVal, input logic [7:0] expSum,
                         input logic expCout, input logic expOvf);
        int edges;
        int busyCycles;
        bit seenDone;
        applyStimulus(1'b1, aVal, bVal, subVal);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        busyCycles = bus8.busy ? 1 : 0;
        edges = 0;
        seenDone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus8.done) begin
                seenDone = 1;
                break;
            end
            if (bus8.busy) busyCycles++;
        end
        checkOutput({tag, "_doneSeen"}, 32'(seenDone), 32'd1);
        checkOutput({tag, "_latency"}, edges, 8);
        checkOutput({tag, "_busyCycles"}, busyCycles, 8);
        checkOutput({tag, "_busyAtDone"}, 32'(bus8.busy), 32'd0);
        checkOutput({tag, "_sum"}, 32'(bus8.sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(bus8.cout), 32'(expCout));
        checkOutput({tag, "_ovf"}, 32'(bus8.ovf), 32'(expOvf));
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, 32'(bus8.done), 32'd0);
        checkOutput({tag, "_sumHold"}, 32'(bus8.sum), 32'(expSum));
    endtask

    initial begin
        logic [9:0] expVec;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        int         w4Edges;
        bit         w4Done;

        totalCount = 0;
        badCount   = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        bus4.start = 1'b0;
        bus4.a     = 4'h0;
        bus4.b     = 4'h0;
        bus4.sub   = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
        checkOutput("rst_done", 32'(bus8.done), 32'd0);
        checkOutput("rst_sum", 32'(bus8.sum), 32'd0);
        checkOutput("rst_cout", 32'(bus8.cout), 32'd0);
        checkOutput("rst_ovf", 32'(bus8.ovf), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic
        runOp("add35_4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        runOp("addFF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        runOp("add7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        runOp("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        runOp("sub80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Handshake: start held high; second op accepted two edges after done
        applyStimulus(1'b1, 8'h01, 8'h02, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) bus8.a = 8'hAA;
            checkOutput($sformatf("hs_done_k%0d", k), 32'(bus8.done),
                        32'((k == 8) || (k == 18)));
            checkOutput($sformatf("hs_busy_k%0d", k), 32'(bus8.busy),
                        32'((k < 8) || ((k >= 10) && (k < 18))));
            if ((k >= 8) && (k < 18))
                checkOutput($sformatf("hs_sum_k%0d", k), 32'(bus8.sum), 32'h03);
            if (k == 18)
                checkOutput("hs_sum_second", 32'(bus8.sum), 32'hAC);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;

        // Reset in the middle of a run, between clock edges
        applyStimulus(1'b1, 8'h55, 8'h22, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("mid_busyBefore", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(bus8.busy), 32'd0);
        checkOutput("mid_done", 32'(bus8.done), 32'd0);
        checkOutput("mid_sum", 32'(bus8.sum), 32'd0);
        checkOutput("mid_cout", 32'(bus8.cout), 32'd0);
        checkOutput("mid_ovf", 32'(bus8.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("after_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // Random vectors against the reference model
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            expVec = refModel(ra, rb, rs);
            runOp($sformatf("rnd%0d_%02h_%02h_%0d", n, ra, rb, rs), ra, rb, rs,
                  expVec[7:0], expVec[8], expVec[9]);
        end

        // WIDTH=4 instance: 7 + 9 wraps to 0 with carry out
        bus4.a     = 4'h7;
        bus4.b     = 4'h9;
        bus4.sub   = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        w4Edges = 0;
        w4Done  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            w4Edges++;
            if (bus4.done) begin
                w4Done = 1;
                break;
            end
        end
        checkOutput("w4_doneSeen", 32'(w4Done), 32'd1);
        checkOutput("w4_latency", w4Edges, 4);
        checkOutput("w4_sum", 32'(bus4.sum), 32'h0);
        checkOutput("w4_cout", 32'(bus4.cout), 32'd1);
        checkOutput("w4_ovf", 32'(bus4.ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
